// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
package hazard_forward_unit_pkg;

  localparam int A3_W = 5;
  localparam int TN_W = 2;

  // Tuse value meaning "operand is never read".
  localparam logic [TN_W-1:0] TUSE_NONE = 2'd3;

  // Forwarding mux select codes; NEAR/FAR are relative to the consuming stage.
  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_NEAR = 2'd1,
    FWD_FAR  = 2'd2
  } fwd_sel_e;

  // One in-flight register writer: destination and cycles until its result exists.
  typedef struct packed {
    logic [A3_W-1:0] a3;
    logic [TN_W-1:0] tnew;
  } slot_t;

  // Count a slot's Tnew down by one stage, holding at zero once the result exists.
  function automatic logic [TN_W-1:0] sat_dec(input logic [TN_W-1:0] t);
    return (t == '0) ? '0 : t - TN_W'(1);
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// D-stage request and hazard/forwarding response bundle.
interface hazard_forward_unit_if
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_W = A3_W,
  parameter int T_W   = TN_W
) ();

  logic             d_valid;
  logic [REG_W-1:0] d_rs;
  logic [REG_W-1:0] d_rt;
  logic [T_W-1:0]   d_tuse_rs;
  logic [T_W-1:0]   d_tuse_rt;
  logic [REG_W-1:0] d_a3;
  logic [T_W-1:0]   d_tnew;
  logic             stall;
  logic [1:0]       fwd_d_rs;
  logic [1:0]       fwd_d_rt;
  logic [1:0]       fwd_e_rs;
  logic [1:0]       fwd_e_rt;

  // The pipeline core presents the D instruction and obeys the selects.
  modport master (
    output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_a3, d_tnew,
    input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt
  );

  // The hazard unit consumes the D instruction and drives the selects.
  modport slave (
    input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_a3, d_tnew,
    output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt
  );

endinterface

// File: rtl/hazard_forward_unit_src_check.sv
// Evaluates one source register against a near and a far producer slot.
// D_MODE=1: nearest match alone decides (stall or forward when ready).
// D_MODE=0: near forwards only when ready, otherwise any far match forwards.
module hazard_forward_unit_src_check
  import hazard_forward_unit_pkg::*;
#(
  parameter bit D_MODE = 1'b1
) (
  input  logic [A3_W-1:0] src,
  input  logic [TN_W-1:0] tuse,
  input  slot_t           near,
  input  slot_t           far,
  output logic            stall,
  output fwd_sel_e        sel
);

  logic near_hit;
  logic far_hit;

  // Register 0 is hard-wired, so it never depends on a producer.
  assign near_hit = (src != '0) && (near.a3 == src);
  assign far_hit  = (src != '0) && (far.a3 == src);

  // Pick the stall condition and select from the nearest matching producer.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    stall = 1'b0;
    sel   = FWD_NONE;
    if (near_hit) begin
      stall = near.tnew > tuse;
      if (near.tnew == '0) begin
        sel = FWD_NEAR;
      end else if (!D_MODE && far_hit) begin
        sel = FWD_FAR;
      end
    end else if (far_hit) begin
      stall = far.tnew > tuse;
      if (!D_MODE || far.tnew == '0) begin
        sel = FWD_FAR;
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard controller for the five-stage core: tracks writers in E/M/W,
// stalls D when a result is late and drives the D/E forwarding selects.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_W = A3_W,
  parameter int T_W   = TN_W
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_forward_unit_if.slave bus
);

  localparam logic [T_W-1:0] TUSE_E = T_W'(TUSE_NONE);

  slot_t            e_slot;
  slot_t            m_slot;
  slot_t            w_slot;
  logic [REG_W-1:0] e_rs;
  logic [REG_W-1:0] e_rt;
  logic             d_rs_stall;
  logic             d_rt_stall;
  logic             stall;
  fwd_sel_e         d_rs_sel;
  fwd_sel_e         d_rt_sel;
  fwd_sel_e         e_rs_sel;
  fwd_sel_e         e_rt_sel;

  assign stall = d_rs_stall | d_rt_stall;

  // Advance the producer slots and the E-stage consumer registers each cycle.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: only this handful of control flops exists, so all of them take the async reset.
    if (reset) begin
      e_slot <= '0;
      m_slot <= '0;
      w_slot <= '0;
      e_rs   <= '0;
      e_rt   <= '0;
    end else begin
      // NOTE: non-blocking so every slot shifts from its pre-edge value.
      if (stall || !bus.d_valid) begin
        e_slot <= '0;
        e_rs   <= '0;
        e_rt   <= '0;
      end else begin
        e_slot <= '{a3: bus.d_a3, tnew: bus.d_tnew};
        e_rs   <= bus.d_rs;
        e_rt   <= bus.d_rt;
      end
      m_slot <= '{a3: e_slot.a3, tnew: sat_dec(e_slot.tnew)};
      w_slot <= '{a3: m_slot.a3, tnew: sat_dec(m_slot.tnew)};
    end
  end

  // D-stage checks: E is nearest, M is next; W is covered by the register file bypass.
  hazard_forward_unit_src_check #(.D_MODE(1'b1)) u_d_rs (
    .src(bus.d_rs), .tuse(bus.d_tuse_rs), .near(e_slot), .far(m_slot),
    .stall(d_rs_stall), .sel(d_rs_sel)
  );

  hazard_forward_unit_src_check #(.D_MODE(1'b1)) u_d_rt (
    .src(bus.d_rt), .tuse(bus.d_tuse_rt), .near(e_slot), .far(m_slot),
    .stall(d_rt_stall), .sel(d_rt_sel)
  );

  // E-stage checks: M is nearest, W is next; these never stall.
  hazard_forward_unit_src_check #(.D_MODE(1'b0)) u_e_rs (
    .src(e_rs), .tuse(TUSE_E), .near(m_slot), .far(w_slot),
    .stall(), .sel(e_rs_sel)
  );

  hazard_forward_unit_src_check #(.D_MODE(1'b0)) u_e_rt (
    .src(e_rt), .tuse(TUSE_E), .near(m_slot), .far(w_slot),
    .stall(), .sel(e_rt_sel)
  );

  assign bus.stall    = stall;
  assign bus.fwd_d_rs = d_rs_sel;
  assign bus.fwd_d_rt = d_rt_sel;
  assign bus.fwd_e_rs = e_rs_sel;
  assign bus.fwd_e_rt = e_rt_sel;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: an instruction-history model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_hazard_forward_unit;
  import hazard_forward_unit_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  bit   cmp_en = 1'b0;

  hazard_forward_unit_if bus ();

  hazard_forward_unit dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist[k] is the instruction that entered E at clock edge k (bubble = all zero).
  // After edge n, the producer of age a (0=E, 1=M, 2=W) is hist[n-a], and its
  // remaining latency is max(0, tnew - a).
  typedef struct {
    int a3;
    int tnew;
    int rs;
    int rt;
  } ent_t;

  ent_t hist [4096];
  int   ncyc       = 0;
  int   valid_from = 1;

  function automatic ent_t ent_at(input int k);
    ent_t e = '{0, 0, 0, 0};
    if (!reset && k >= 1 && k >= valid_from) e = hist[k % 4096];
    return e;
  endfunction

  function automatic void model_d(input int r, input int tuse, output bit st, output int sel);
    st  = 1'b0;
    sel = 0;
    if (r != 0) begin
      for (int age = 0; age < 2; age++) begin
        ent_t p = ent_at(ncyc - age);
        if (p.a3 == r) begin
          int rem = (p.tnew > age) ? p.tnew - age : 0;
          st  = rem > tuse;
          sel = (!st && rem == 0) ? age + 1 : 0;
          return;
        end
      end
    end
  endfunction

  function automatic int model_e(input int r);
    ent_t p;
    ent_t q;
    if (r == 0) return 0;
    p = ent_at(ncyc - 1);
    if (p.a3 == r && p.tnew <= 1) return 1;
    q = ent_at(ncyc - 2);
    if (q.a3 == r) return 2;
    return 0;
  endfunction

  // Record what enters E at each edge, using the model's own stall decision.
  always @(posedge clk) begin
    bit   s1, s2;
    int   x1, x2;
    ent_t e;
    model_d(int'(bus.d_rs), int'(bus.d_tuse_rs), s1, x1);
    model_d(int'(bus.d_rt), int'(bus.d_tuse_rt), s2, x2);
    e = '{0, 0, 0, 0};
    if (bus.d_valid === 1'b1 && !(s1 || s2))
      e = '{int'(bus.d_a3), int'(bus.d_tnew), int'(bus.d_rs), int'(bus.d_rt)};
    ncyc++;
    if (reset) valid_from = ncyc + 1;
    else hist[ncyc % 4096] = e;
  end

  // An asynchronous reset forgets every in-flight producer at once.
  always @(posedge reset) valid_from = ncyc + 1;

  // Compare DUT outputs against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      bit s1, s2;
      int x1, x2;
      model_d(int'(bus.d_rs), int'(bus.d_tuse_rs), s1, x1);
      model_d(int'(bus.d_rt), int'(bus.d_tuse_rt), s2, x2);
      check("cmp stall", bus.stall, s1 || s2);
      if (!(s1 || s2)) begin
        check("cmp fwd_d_rs", bus.fwd_d_rs, x1);
        check("cmp fwd_d_rt", bus.fwd_d_rt, x2);
      end
      check("cmp fwd_e_rs", bus.fwd_e_rs, model_e(ent_at(ncyc).rs));
      check("cmp fwd_e_rt", bus.fwd_e_rt, model_e(ent_at(ncyc).rt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input int rs, input int rt, input int tr, input int tt,
                       input int a3, input int tn);
    bus.d_valid   = v;
    bus.d_rs      = 5'(rs);
    bus.d_rt      = 5'(rt);
    bus.d_tuse_rs = 2'(tr);
    bus.d_tuse_rt = 2'(tt);
    bus.d_a3      = 5'(a3);
    bus.d_tnew    = 2'(tn);
  endtask

  // Hold one instruction in D until it is accepted; report stall cycles,
  // the D selects on the accepting cycle and the E selects on the first cycle.
  task automatic issue(input bit v, input int rs, input int rt, input int tr, input int tt,
                       input int a3, input int tn, output int stalls, output int fd_rs,
                       output int fd_rt, output int fe_rs0, output int fe_rt0);
    bit s;
    bit done = 1'b0;
    drive(v, rs, rt, tr, tt, a3, tn);
    stalls = 0;
    fd_rs = 0; fd_rt = 0; fe_rs0 = 0; fe_rt0 = 0;
    for (int g = 0; g < 8 && !done; g++) begin
      @(negedge clk);
      if (g == 0) begin
        fe_rs0 = int'(bus.fwd_e_rs);
        fe_rt0 = int'(bus.fwd_e_rt);
      end
      s     = bus.stall;
      fd_rs = int'(bus.fwd_d_rs);
      fd_rt = int'(bus.fwd_d_rt);
      @(posedge clk);
      #1;
      if (s) stalls++;
      else done = 1'b1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue timeout: stalled %0d cycles, expected acceptance within 8", stalls);
    end
  endtask

  task automatic flush();
    int st, a, b, c, d;
    repeat (3) issue(1'b0, 0, 0, 3, 3, 0, 0, st, a, b, c, d);
  endtask

  initial begin
    int st, a, b, c, d;
    drive(1'b0, 0, 0, 3, 3, 0, 0);
    reset = 1'b1;

    // Reset state: a hazardous-looking D input still yields no stall or forward.
    drive(1'b1, 8, 9, 0, 0, 8, 2);
    @(negedge clk);
    cmp_en = 1'b1;
    check("reset stall", bus.stall, 0);
    check("reset fwd_d_rs", bus.fwd_d_rs, 0);
    check("reset fwd_e_rt", bus.fwd_e_rt, 0);
    drive(1'b0, 0, 0, 3, 3, 0, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // lw $8 (tnew 2) then add rs=$8 (tuse 1): one stall, then regfile; W forward in E.
    issue(1'b1, 0, 0, 3, 3, 8, 2, st, a, b, c, d);
    issue(1'b1, 8, 0, 1, 3, 10, 1, st, a, b, c, d);
    check("lw-add stalls", st, 1);
    check("lw-add fwd_d_rs", a, 0);
    issue(1'b0, 0, 0, 3, 3, 0, 0, st, a, b, c, d);
    check("lw-add fwd_e_rs", c, 2);
    flush();

    // addu $9 (tnew 1) then beq rs=$9 (tuse 0): one stall, then forward from M.
    issue(1'b1, 0, 0, 3, 3, 9, 1, st, a, b, c, d);
    issue(1'b1, 9, 0, 0, 3, 0, 0, st, a, b, c, d);
    check("addu-beq stalls", st, 1);
    check("addu-beq fwd_d_rs", a, 2);
    flush();

    // jal ($31, tnew 0) then jr $31 (tuse 0): no stall, forward from E.
    issue(1'b1, 0, 0, 3, 3, 31, 0, st, a, b, c, d);
    issue(1'b1, 31, 0, 0, 3, 0, 0, st, a, b, c, d);
    check("jal-jr stalls", st, 0);
    check("jal-jr fwd_d_rs", a, 1);
    flush();

    // Write to $0 (tnew 2) then reader of $0: register 0 never matches.
    issue(1'b1, 0, 0, 3, 3, 0, 2, st, a, b, c, d);
    issue(1'b1, 0, 0, 0, 0, 0, 0, st, a, b, c, d);
    check("r0 stalls", st, 0);
    check("r0 fwd_d_rs", a, 0);
    check("r0 fwd_d_rt", b, 0);
    check("r0 fwd_e_rs", c, 0);
    check("r0 fwd_e_rt", d, 0);
    flush();

    // ori $8 then addu $8 then reader of $8: E stage takes M (newer), not W.
    issue(1'b1, 0, 0, 3, 3, 8, 1, st, a, b, c, d);
    issue(1'b1, 0, 0, 3, 3, 8, 1, st, a, b, c, d);
    issue(1'b1, 8, 0, 1, 3, 0, 0, st, a, b, c, d);
    check("ori-addu reader stalls", st, 0);
    issue(1'b0, 0, 0, 3, 3, 0, 0, st, a, b, c, d);
    check("ori-addu fwd_e_rs", c, 1);
    flush();

    // Same a3 in E and M: D check uses E (not ready, tuse 2), never the older M value.
    issue(1'b1, 0, 0, 3, 3, 5, 1, st, a, b, c, d);
    issue(1'b1, 0, 0, 3, 3, 5, 1, st, a, b, c, d);
    issue(1'b1, 5, 0, 2, 3, 0, 0, st, a, b, c, d);
    check("dup-a3 stalls", st, 0);
    check("dup-a3 fwd_d_rs", a, 0);
    flush();

    // Stall length tnew - tuse: lw (2) -> beq (0), and tnew 3 -> rt tuse 1.
    issue(1'b1, 0, 0, 3, 3, 8, 2, st, a, b, c, d);
    issue(1'b1, 8, 0, 0, 3, 0, 0, st, a, b, c, d);
    check("lw-beq stalls", st, 2);
    flush();
    issue(1'b1, 0, 0, 3, 3, 7, 3, st, a, b, c, d);
    issue(1'b1, 0, 7, 3, 1, 4, 1, st, a, b, c, d);
    check("tnew3 rt stalls", st, 2);
    flush();

    // Reset asserted mid-stall clears everything immediately.
    issue(1'b1, 0, 0, 3, 3, 8, 2, st, a, b, c, d);
    drive(1'b1, 8, 0, 0, 3, 0, 0);
    @(negedge clk);
    check("pre-reset stall", bus.stall, 1);
    #2 reset = 1'b1;
    #1;
    check("async reset stall", bus.stall, 0);
    check("async reset fwd_d_rs", bus.fwd_d_rs, 0);
    check("async reset fwd_d_rt", bus.fwd_d_rt, 0);
    check("async reset fwd_e_rs", bus.fwd_e_rs, 0);
    check("async reset fwd_e_rt", bus.fwd_e_rt, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    issue(1'b1, 8, 0, 0, 3, 0, 0, st, a, b, c, d);
    check("post-reset stalls", st, 0);
    check("post-reset fwd_d_rs", a, 0);
    flush();

    // Dense mixed traffic on a few registers, checked by the per-cycle model.
    for (int i = 0; i < 80; i++) begin
      issue(($urandom_range(0, 9) != 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), st, a, b, c, d);
    end
    flush();

    @(posedge clk);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
